// File: rtl/alu_operand_stack.sv
// Operand stack feeding a combinational stack ALU: exposes the top two entries
// and writes ALU results back under a per-cycle 3-bit command.
module alu_operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] res0,
  input  logic [WIDTH-1:0] res1,
  input  logic             clr_err,
  output logic [WIDTH-1:0] stack0,
  output logic [WIDTH-1:0] stack1,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_PUSH  = 3'b001,
    CMD_POP   = 3'b010,
    CMD_BIN   = 3'b011,
    CMD_PAIR  = 3'b100,
    CMD_DUP   = 3'b101,
    CMD_SWAP  = 3'b110,
    CMD_UNARY = 3'b111
  } cmd_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  cmd_e             cmd_op;
  logic [AW-1:0]    top_idx, nxt_idx, push_idx;
  logic             has_one, has_two, has_room;

  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_addr, wr1_addr;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  assign cmd_op   = cmd_e'(cmd);
  assign top_idx  = AW'(count_q - CW'(1));
  assign nxt_idx  = AW'(count_q - CW'(2));
  assign push_idx = AW'(count_q);
  assign has_one  = (count_q != '0);
  assign has_two  = (count_q >= CW'(2));
  assign has_room = (count_q != CW'(DEPTH));

  // Indices below are only dereferenced when the count gate says the slot is live.
  assign stack0 = has_one ? mem_q[top_idx] : '0;
  assign stack1 = has_two ? mem_q[nxt_idx] : '0;
  assign count  = count_q;
  assign full   = ~has_room;
  assign empty  = ~has_one;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q & ~clr_err;
    unf_d    = unf_q & ~clr_err;
    wr0_en   = 1'b0;
    wr0_addr = top_idx;
    wr0_data = res0;
    wr1_en   = 1'b0;
    wr1_addr = nxt_idx;
    wr1_data = res1;

    case (cmd_op)
      CMD_PUSH: begin
        if (has_room) begin
          wr0_en   = 1'b1;
          wr0_addr = push_idx;
          wr0_data = din;
          count_d  = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      CMD_POP: begin
        if (has_one) count_d = count_q - CW'(1);
        else         unf_d   = 1'b1;
      end
      CMD_BIN: begin
        if (has_two) begin
          wr0_en   = 1'b1;
          wr0_addr = nxt_idx;
          wr0_data = res0;
          count_d  = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      CMD_PAIR: begin
        if (has_two) begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      CMD_DUP: begin
        // An empty stack reports underflow even though there is room.
        if (!has_one) begin
          unf_d = 1'b1;
        end else if (!has_room) begin
          ovf_d = 1'b1;
        end else begin
          wr0_en   = 1'b1;
          wr0_addr = push_idx;
          wr0_data = stack0;
          count_d  = count_q + CW'(1);
        end
      end
      CMD_SWAP: begin
        if (has_two) begin
          wr0_en   = 1'b1;
          wr0_data = stack1;
          wr1_en   = 1'b1;
          wr1_data = stack0;
        end else begin
          unf_d = 1'b1;
        end
      end
      CMD_UNARY: begin
        if (has_one) wr0_en = 1'b1;
        else         unf_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: entry storage has no reset; the count gate hides stale contents,
  // which lets this map onto plain RAM or unreset flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr0_en) mem_q[wr0_addr] <= wr0_data;
      if (wr1_en) mem_q[wr1_addr] <= wr1_data;
    end
  end

endmodule

// File: tb/tb_alu_operand_stack.sv
// Scoreboard bench for alu_operand_stack: a queue-based stack model predicts
// the visible state after each command; a monitor compares on the falling edge.
module tb_alu_operand_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, BIN = 3'd3,
                         PAIR = 3'd4, DUP = 3'd5, SWAP = 3'd6, UNARY = 3'd7;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] din, res0, res1;
  logic             clr_err;
  logic [WIDTH-1:0] stack0, stack1;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, unf;

  alu_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .din(din), .res0(res0), .res1(res1),
    .clr_err(clr_err), .stack0(stack0), .stack1(stack1), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         s0, s1, cnt;
    bit         full, empty, ovf, unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: a plain queue whose back is the top of stack.
  logic [WIDTH-1:0] m_stk[$];
  bit               m_ovf, m_unf;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t snapshot(input string tag);
    exp_t e;
    int n = m_stk.size();
    e.tag   = tag;
    e.s0    = (n >= 1) ? int'(m_stk[n-1]) : 0;
    e.s1    = (n >= 2) ? int'(m_stk[n-2]) : 0;
    e.cnt   = n;
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_step(input logic [2:0] c, input logic [WIDTH-1:0] d,
                            input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1,
                            input bit clr);
    int n = m_stk.size();
    logic [WIDTH-1:0] t;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    case (c)
      PUSH:  if (n < DEPTH) m_stk.push_back(d); else m_ovf = 1;
      POP:   if (n >= 1) void'(m_stk.pop_back()); else m_unf = 1;
      BIN:   if (n >= 2) begin void'(m_stk.pop_back()); m_stk[n-2] = r0; end
             else m_unf = 1;
      PAIR:  if (n >= 2) begin m_stk[n-1] = r0; m_stk[n-2] = r1; end
             else m_unf = 1;
      DUP:   if (n == 0) m_unf = 1;
             else if (n == DEPTH) m_ovf = 1;
             else m_stk.push_back(m_stk[n-1]);
      SWAP:  if (n >= 2) begin t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; end
             else m_unf = 1;
      UNARY: if (n >= 1) m_stk[n-1] = r0; else m_unf = 1;
      default: ;
    endcase
  endtask

  // Drive one command, let it take effect at the edge, queue the prediction.
  task automatic do_cmd(input string tag, input logic [2:0] c, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1,
                        input bit clr);
    cmd = c; din = d; res0 = r0; res1 = r1; clr_err = clr;
    @(posedge clk);
    model_step(c, d, r0, r1, clr);
    sb_q.push_back(snapshot(tag));
    @(negedge clk);
    cmd = NOP; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_stk.delete(); m_ovf = 0; m_unf = 0;
    check("reset_count", int'(count), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_flags", int'({ovf, unf}), 0);
    reset = 1'b0;
  endtask

  // Monitor: outputs are registered-state only, so the falling edge is stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".stack0"}, int'(stack0), e.s0);
        check({e.tag, ".stack1"}, int'(stack1), e.s1);
        check({e.tag, ".count"},  int'(count),  e.cnt);
        check({e.tag, ".full"},   int'(full),   int'(e.full));
        check({e.tag, ".empty"},  int'(empty),  int'(e.empty));
        check({e.tag, ".ovf"},    int'(ovf),    int'(e.ovf));
        check({e.tag, ".unf"},    int'(unf),    int'(e.unf));
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; cmd = NOP; din = '0; res0 = '0; res1 = '0; clr_err = 1'b0;
    m_ovf = 0; m_unf = 0;
    #12;
    @(negedge clk);
    apply_reset();

    // Binary op collapses two entries into one.
    do_cmd("push34", PUSH, 8'd34, 8'd0, 8'd0, 0);
    do_cmd("push76", PUSH, 8'd76, 8'd0, 8'd0, 0);
    check("spec_push_top", int'(stack0), 76);
    do_cmd("bin110", BIN, 8'd0, 8'd110, 8'd0, 0);
    check("spec_bin_top", int'(stack0), 110);

    apply_reset();
    do_cmd("push30", PUSH, 8'd30, 8'd0, 8'd0, 0);
    do_cmd("push50", PUSH, 8'd50, 8'd0, 8'd0, 0);
    do_cmd("swap",   SWAP, 8'd0,  8'd0, 8'd0, 0);
    check("spec_swap_top", int'(stack0), 30);
    do_cmd("pair",   PAIR, 8'd0,  8'd7, 8'd9, 0);

    // Fill to capacity, then overflow by PUSH and by DUP.
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) do_cmd("fill", PUSH, WIDTH'(i), 8'd0, 8'd0, 0);
    check("spec_full", int'(full), 1);
    do_cmd("push_full", PUSH, 8'd99, 8'd0, 8'd0, 0);
    check("spec_ovf_top", int'(stack0), DEPTH);
    do_cmd("dup_full",  DUP,  8'd0,  8'd0, 8'd0, 0);

    // Underflow, and clear racing a new error.
    apply_reset();
    do_cmd("pop_empty",   POP,   8'd0, 8'd0, 8'd0, 0);
    do_cmd("unary_empty", UNARY, 8'd0, 8'd0, 8'd0, 0);
    do_cmd("dup_empty",   DUP,   8'd0, 8'd0, 8'd0, 0);
    do_cmd("clr_and_pop", POP,   8'd0, 8'd0, 8'd0, 1);
    check("spec_unf_wins", int'(unf), 1);
    do_cmd("clr_alone",   NOP,   8'd0, 8'd0, 8'd0, 1);
    check("spec_unf_clr", int'(unf), 0);
    do_cmd("push5",   PUSH,  8'd5, 8'd0,   8'd0, 0);
    do_cmd("swap1",   SWAP,  8'd0, 8'd0,   8'd0, 0);
    do_cmd("bin1",    BIN,   8'd0, 8'd1,   8'd0, 0);
    do_cmd("unary",   UNARY, 8'd0, 8'd251, 8'd0, 0);
    do_cmd("dup",     DUP,   8'd0, 8'd0,   8'd0, 0);
    check("spec_dup_s1", int'(stack1), 251);

    // Asynchronous reset between edges, held across an edge with a PUSH pending.
    apply_reset();
    for (int i = 0; i < 3; i++) do_cmd("pre_async", PUSH, WIDTH'(10 + i), 8'd0, 8'd0, 0);
    #2;
    cmd = PUSH; din = 8'd200;
    reset = 1'b1;
    #1;
    check("async_count",  int'(count),  0);
    check("async_empty",  int'(empty),  1);
    check("async_stack0", int'(stack0), 0);
    @(posedge clk);
    @(negedge clk);
    check("reset_ignores_cmd", int'(count), 0);
    m_stk.delete(); m_ovf = 0; m_unf = 0;
    reset = 1'b0; cmd = NOP;
    do_cmd("post_reset_push", PUSH, 8'd1, 8'd0, 8'd0, 0);

    // Randomized traffic, biased toward pushes so the full boundary is visited.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] c;
      int sel = $urandom_range(0, 15);
      c = (sel < 5) ? PUSH : 3'($urandom_range(0, 7));
      do_cmd("rand", c, 8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    budget = 0;
    while (sb_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
